// File: rtl/inst_fetch_queue.sv
// Instruction fetch front-end. It issues sequential word fetches to a
// variable-latency instruction memory and queues the returned instructions,
// in order, with their PCs for decode. A redirect flushes the queue, and
// responses to wrong-path requests are counted off and dropped.
module inst_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     resetn,
  output logic                     oMemReq,
  output logic [ADDR_W-1:0]        oMemAddr,
  input  logic                     iMemAck,
  input  logic                     iMemValid,
  input  logic [INST_W-1:0]        iMemData,
  input  logic                     iRedirect,
  input  logic [ADDR_W-1:0]        iRedirectPC,
  input  logic                     iStall,
  output logic                     oInstValid,
  output logic [INST_W-1:0]        oInst,
  output logic [ADDR_W-1:0]        oInstPC,
  output logic [$clog2(DEPTH):0]   oCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_REDIR} state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [ADDR_W-1:0] r_fetchPC;
  logic [CW-1:0]     r_inflight;
  logic [CW-1:0]     r_discard;
  logic [CW-1:0]     r_count;
  logic [AW-1:0]     r_qHead;
  logic [AW-1:0]     r_qTail;
  logic [AW-1:0]     r_pfHead;
  logic [AW-1:0]     r_pfTail;

  logic [INST_W-1:0] r_qInst [DEPTH];
  logic [ADDR_W-1:0] r_qPC   [DEPTH];
  logic [ADDR_W-1:0] r_pfPC  [DEPTH];

  logic              w_ack;
  logic              w_push;
  logic              w_pop;
  logic [CW-1:0]     w_ackInc;
  logic [CW-1:0]     w_validDec;
  logic [CW-1:0]     w_pushInc;
  logic [CW-1:0]     w_popDec;
  logic [CW-1:0]     w_inflightNext;
  logic [CW-1:0]     w_countNext;
  logic [CW-1:0]     w_discardNext;
  logic [CW:0]       w_creditSum;
  logic              w_creditNext;
  logic              w_unusedPCBits;

  // The low redirect address bits are ignored because fetches are word aligned.
  assign w_unusedPCBits = ^iRedirectPC[1:0];

  assign w_ack      = oMemReq & iMemAck;
  assign w_push     = iMemValid & (r_discard == '0) & ~iRedirect;
  assign w_pop      = oInstValid & ~iStall & ~iRedirect;
  assign w_ackInc   = w_ack     ? ONE_C : '0;
  assign w_validDec = iMemValid ? ONE_C : '0;
  assign w_pushInc  = w_push    ? ONE_C : '0;
  assign w_popDec   = w_pop     ? ONE_C : '0;

  // Every response returns one credit, dropped or not; the discard count is
  // reloaded from the in-flight total so that all older data gets dropped.
  assign w_inflightNext = r_inflight + w_ackInc - w_validDec;
  assign w_countNext    = iRedirect ? '0 : (r_count + w_pushInc - w_popDec);
  assign w_discardNext  = iRedirect ? w_inflightNext :
                          ((iMemValid && (r_discard != '0)) ? (r_discard - ONE_C) : r_discard);
  assign w_creditSum    = {1'b0, w_inflightNext} + {1'b0, w_countNext};
  assign w_creditNext   = (w_creditSum < {1'b0, DEPTH_C});

  // Request state register; reset lands in WAIT so the request output is low during reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_WAIT;
    else         r_state <= w_stateNext;
  end

  // Next request state from next-cycle credit, with redirect taking priority.
  always_comb begin
    w_stateNext = r_state;
    oMemReq     = 1'b0;
    oMemAddr    = r_fetchPC;
    if (r_state == S_REQ) oMemReq = 1'b1;
    if (iRedirect)         w_stateNext = S_REDIR;
    else if (w_creditNext) w_stateNext = S_REQ;
    else                   w_stateNext = S_WAIT;
  end

  // Fetch PC, credit counters, and queue and PC-FIFO pointers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fetchPC  <= RESET_PC;
      r_inflight <= '0;
      r_discard  <= '0;
      r_count    <= '0;
      r_qHead    <= '0;
      r_qTail    <= '0;
      r_pfHead   <= '0;
      r_pfTail   <= '0;
    end else begin
      r_inflight <= w_inflightNext;
      r_discard  <= w_discardNext;
      r_count    <= w_countNext;
      if (iRedirect)  r_fetchPC <= {iRedirectPC[ADDR_W-1:2], 2'b00};
      else if (w_ack) r_fetchPC <= r_fetchPC + ADDR_W'(4);
      if (w_ack)      r_pfTail  <= r_pfTail + AW'(1);
      if (iMemValid)  r_pfHead  <= r_pfHead + AW'(1);
      if (iRedirect) begin
        r_qHead <= '0;
        r_qTail <= '0;
      end else begin
        if (w_push) r_qTail <= r_qTail + AW'(1);
        if (w_pop)  r_qHead <= r_qHead + AW'(1);
      end
    end
  end

  // Storage: the PC of each accepted request, and queued instructions paired with the oldest in-flight PC.
  always_ff @(posedge clk) begin
    if (w_ack) r_pfPC[r_pfTail] <= r_fetchPC;
    if (w_push) begin
      r_qInst[r_qTail] <= iMemData;
      r_qPC[r_qTail]   <= r_pfPC[r_pfHead];
    end
  end

  assign oInstValid = (r_count != '0);
  assign oInst      = oInstValid ? r_qInst[r_qHead] : '0;
  assign oInstPC    = oInstValid ? r_qPC[r_qHead]   : '0;
  assign oCount     = r_count;

  // The credit limit keeps a push from ever landing on a full queue.
  pushNotFull: assert property (@(posedge clk) disable iff (!resetn)
                                !(w_push && (r_count == DEPTH_C)));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue. A behavioural memory answers
// requests after a programmable latency. Every accepted request pushes its
// expected PC onto a scoreboard, a redirect clears the scoreboard, and each
// presented head instruction is compared against the oldest scoreboard entry.
module tb_inst_fetch_queue;

  localparam logic [31:0] RESET_PC_TB = 32'h0;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        oMemReq;
  logic [31:0] oMemAddr;
  logic        iMemAck = 1'b0;
  logic        iMemValid = 1'b0;
  logic [31:0] iMemData = '0;
  logic        iRedirect = 1'b0;
  logic [31:0] iRedirectPC = '0;
  logic        iStall = 1'b0;
  logic        oInstValid;
  logic [31:0] oInst;
  logic [31:0] oInstPC;
  logic [2:0]  oCount;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  memReq_t     memQ[$];
  logic [31:0] sb[$];
  logic [31:0] presented[$];
  logic [31:0] expPC = RESET_PC_TB;
  int          cycle = 0;
  int          memLat = 1;
  logic        pendReq = 1'b0;
  int          checkCount = 0;
  int          errorCount = 0;

  inst_fetch_queue #(
    .ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(RESET_PC_TB)
  ) dut (
    .clk(clk), .resetn(resetn),
    .oMemReq(oMemReq), .oMemAddr(oMemAddr), .iMemAck(iMemAck),
    .iMemValid(iMemValid), .iMemData(iMemData),
    .iRedirect(iRedirect), .iRedirectPC(iRedirectPC), .iStall(iStall),
    .oInstValid(oInstValid), .oInst(oInst), .oInstPC(oInstPC), .oCount(oCount)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, actual, expected, cycle);
    end
  endtask

  task automatic checkPresented(input string tag, input int idx, input logic [31:0] expected);
    if (presented.size() > idx) checkOutput(tag, presented[idx], expected);
    else checkOutput({tag, "_count"}, 32'(presented.size()), 32'(idx + 1));
  endtask

  // Drive one cycle of stimulus, then advance to just after the next rising edge.
  task automatic applyStimulus(input logic stall, input logic redir, input logic [31:0] rpc, input logic ack);
    iMemValid = 1'b0;
    iMemData  = '0;
    if (memQ.size() > 0 && memQ[0].due <= cycle) begin
      iMemValid = 1'b1;
      iMemData  = memQ[0].addr | 32'hA000_0000;
      void'(memQ.pop_front());
    end
    iMemAck     = ack;
    iStall      = stall;
    iRedirect   = redir;
    iRedirectPC = rpc;
    if (pendReq) checkOutput("reqHeld", {31'b0, oMemReq}, 32'h1);
    if (oInstValid) begin
      if (sb.size() == 0) begin
        checkOutput("spuriousValid", {31'b0, oInstValid}, 32'h0);
      end else begin
        checkOutput("headPC", oInstPC, sb[0]);
        checkOutput("headInst", oInst, sb[0] | 32'hA000_0000);
        if (!stall && !redir) begin
          presented.push_back(oInstPC);
          void'(sb.pop_front());
        end
      end
    end else begin
      checkOutput("emptyInst", oInst, 32'h0);
      checkOutput("emptyPC", oInstPC, 32'h0);
    end
    if (oMemReq && ack) begin
      checkOutput("memAddr", oMemAddr, expPC);
      memQ.push_back('{addr: oMemAddr, due: cycle + memLat});
      sb.push_back(expPC);
      expPC = expPC + 32'd4;
    end
    if (redir) begin
      sb.delete();
      expPC = rpc & 32'hFFFF_FFFC;
    end
    pendReq = oMemReq && !ack && !redir;
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic doReset();
    resetn    = 1'b0;
    iMemAck   = 1'b0;
    iMemValid = 1'b0;
    iRedirect = 1'b0;
    iStall    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstReq", {31'b0, oMemReq}, 32'h0);
    checkOutput("rstValid", {31'b0, oInstValid}, 32'h0);
    checkOutput("rstCount", 32'(oCount), 32'h0);
    checkOutput("rstInst", oInst, 32'h0);
    checkOutput("rstPC", oInstPC, 32'h0);
    memQ.delete();
    sb.delete();
    presented.delete();
    expPC   = RESET_PC_TB;
    pendReq = 1'b0;
    resetn  = 1'b1;
    @(posedge clk);
    #1;
    cycle++;
    checkOutput("firstReq", {31'b0, oMemReq}, 32'h1);
    checkOutput("firstAddr", oMemAddr, RESET_PC_TB);
  endtask

  initial begin
    logic found;
    logic prevRedir;
    logic redirNow;

    // Streaming with a one-cycle memory.
    memLat = 1;
    doReset();
    for (int i = 0; i < 20; i++) begin
      checkOutput("latValid", {31'b0, oInstValid}, (i >= 2) ? 32'h1 : 32'h0);
      checkOutput("countLe1", {31'b0, (oCount <= 3'd1)}, 32'h1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    end
    checkPresented("streamPC0", 0, 32'h0);
    checkPresented("streamPC1", 1, 32'h4);
    checkPresented("streamPC2", 2, 32'h8);
    checkPresented("streamPC3", 3, 32'hC);

    // Stall until the queue saturates, then release.
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("satCount", 32'(oCount), 32'h4);
    checkOutput("satReq", {31'b0, oMemReq}, 32'h0);
    checkOutput("satInflight", 32'(memQ.size()), 32'h0);
    checkOutput("satHoldPC", oInstPC, 32'h0);
    for (int i = 0; i < 8; i++) begin
      checkOutput("noGap", {31'b0, oInstValid}, 32'h1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    end
    checkPresented("relPC0", 0, 32'h0);
    checkPresented("relPC1", 1, 32'h4);
    checkPresented("relPC2", 2, 32'h8);
    checkPresented("relPC3", 3, 32'hC);
    checkPresented("relPC4", 4, 32'h10);

    // Three-cycle memory with a redirect while two requests are in flight.
    memLat = 3;
    doReset();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1);
    checkOutput("redirValid", {31'b0, oInstValid}, 32'h0);
    checkOutput("redirReq", {31'b0, oMemReq}, 32'h0);
    presented.delete();
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkPresented("redir100", 0, 32'h100);

    // Redirect in a cycle that also has a response and an acknowledge.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (oMemReq && memQ.size() > 0 && memQ[0].due <= cycle) begin
        applyStimulus(1'b0, 1'b1, 32'h203, 1'b1);
        found = 1'b1;
      end else begin
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      end
    end
    checkOutput("collideFound", {31'b0, found}, 32'h1);
    checkOutput("collideValid", {31'b0, oInstValid}, 32'h0);
    presented.delete();
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkPresented("redir200", 0, 32'h200);

    // A second redirect while older wrong-path data is still being discarded.
    applyStimulus(1'b0, 1'b1, 32'h400, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b1);
    presented.delete();
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkPresented("redir300", 0, 32'h300);

    // Fetch address wrap-around.
    memLat = 1;
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    presented.delete();
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkPresented("wrapPC0", 0, 32'hFFFF_FFF8);
    checkPresented("wrapPC1", 1, 32'hFFFF_FFFC);
    checkPresented("wrapPC2", 2, 32'h0);

    // Randomised acknowledges, stalls and redirects with a two-cycle memory.
    memLat = 2;
    prevRedir = 1'b0;
    for (int i = 0; i < 300; i++) begin
      redirNow = !prevRedir && ($urandom_range(0, 31) == 0);
      applyStimulus($urandom_range(0, 3) == 0, redirNow, $urandom, $urandom_range(0, 3) != 0);
      prevRedir = redirNow;
    end

    // Asynchronous reset with three instructions queued.
    memLat = 1;
    doReset();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      if (oCount == 3'd3) found = 1'b1;
    end
    checkOutput("fillTo3", {31'b0, found}, 32'h1);
    #3;
    resetn = 1'b0;
    #1;
    checkOutput("asyncValid", {31'b0, oInstValid}, 32'h0);
    checkOutput("asyncReq", {31'b0, oMemReq}, 32'h0);
    checkOutput("asyncCount", 32'(oCount), 32'h0);
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkPresented("postRstPC0", 0, RESET_PC_TB);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
